// File: rtl/rv32_imm_gen_pkg.sv
// rtl/rv32_imm_gen_pkg.sv - shared immediate-format select encoding for the RV32I decode stage
package rv32_imm_gen_pkg;

    typedef logic [2:0] imm_sel_t;

    localparam imm_sel_t IMM_I = 3'd0;
    localparam imm_sel_t IMM_S = 3'd1;
    localparam imm_sel_t IMM_B = 3'd2;
    localparam imm_sel_t IMM_U = 3'd3;
    localparam imm_sel_t IMM_J = 3'd4;
    localparam imm_sel_t IMM_Z = 3'd5;

endpackage

// File: rtl/rv32_imm_gen.sv
// rtl/rv32_imm_gen.sv - RV32I immediate generator with combinational and registered outputs
// Define IMM_GEN_J_SEXT_EN to sign-extend J-type offsets; by default they are zero-extended.
module rv32_imm_gen
    import rv32_imm_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic [2:0]  imm_sel,
    output logic [31:0] imm,
    output logic [31:0] imm_q
);

    logic [10:0] w_j_upper;
    logic [31:0] r_imm_q;

`ifdef IMM_GEN_J_SEXT_EN
    assign w_j_upper = {11{instruction[31]}};
`else
    assign w_j_upper = 11'd0;
`endif

    // Opcode bits [6:0] are never consulted; the control decoder owns format selection.
    always_comb begin
        imm = 32'd0;
        case (imm_sel_t'(imm_sel))
            IMM_I: imm = {{21{instruction[31]}}, instruction[30:20]};
            IMM_S: imm = {{21{instruction[31]}}, instruction[30:25], instruction[11:7]};
            IMM_B: imm = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                          instruction[11:8], 1'b0};
            IMM_U: imm = {instruction[31:12], 12'd0};
            IMM_J: imm = {w_j_upper, instruction[31], instruction[19:12], instruction[20],
                          instruction[30:21], 1'b0};
            IMM_Z: imm = {27'd0, instruction[19:15]};
            default: imm = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm_q <= 32'd0;
        end else begin
            r_imm_q <= imm;
        end
    end

    assign imm_q = r_imm_q;

endmodule

// File: tb/tb_rv32_imm_gen.sv
// tb/tb_rv32_imm_gen.sv - directed self-checking bench for rv32_imm_gen
module tb_rv32_imm_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [2:0]  imm_sel;
    logic [31:0] imm;
    logic [31:0] imm_q;

    int checks;
    int errors;

    rv32_imm_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .imm_sel     (imm_sel),
        .imm         (imm),
        .imm_q       (imm_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        instruction = 32'd0;
        imm_sel     = 3'd0;

        // Asynchronous clear with no clock edge nearby.
        #2 rst_n = 1'b0;
        #1 check_eq("reset_async", imm_q, 32'h0);

        vecs.push_back('{"i_neg",     32'hFFF00093, 3'd0, 32'hFFFFFFFF});
        vecs.push_back('{"i_pos",     32'h7FF00093, 3'd0, 32'h000007FF});
        vecs.push_back('{"i_opc_ign", 32'h7FF0007F, 3'd0, 32'h000007FF});
        vecs.push_back('{"s_neg",     32'hFE1121A3, 3'd1, 32'hFFFFFFE3});
        vecs.push_back('{"s_pos",     32'h00A12223, 3'd1, 32'h00000004});
        vecs.push_back('{"b_neg",     32'hFE116F63, 3'd2, 32'hFFFFF7FE});
        vecs.push_back('{"u_all",     32'hFFFFF037, 3'd3, 32'hFFFFF000});
        vecs.push_back('{"u_mix",     32'h12345678, 3'd3, 32'h12345000});
`ifdef IMM_GEN_J_SEXT_EN
        vecs.push_back('{"j_neg",     32'hFFFFF06F, 3'd4, 32'hFFFFFFFE});
`else
        vecs.push_back('{"j_neg",     32'hFFFFF06F, 3'd4, 32'h001FFFFE});
`endif
        vecs.push_back('{"j_pos",     32'h0080006F, 3'd4, 32'h00000008});
        vecs.push_back('{"z_1f",      32'h000F8073, 3'd5, 32'h0000001F});
        vecs.push_back('{"z_ones",    32'hFFFFFFFF, 3'd5, 32'h0000001F});
        vecs.push_back('{"rsv6",      32'h000F8073, 3'd6, 32'h00000000});
        vecs.push_back('{"rsv7",      32'h000F8073, 3'd7, 32'h00000000});
        vecs.push_back('{"rsv6_ones", 32'hFFFFFFFF, 3'd6, 32'h00000000});
        vecs.push_back('{"rsv7_ones", 32'hFFFFFFFF, 3'd7, 32'h00000000});

        foreach (vecs[k]) begin
            instruction = vecs[k].instr;
            imm_sel     = vecs[k].sel;
            #1 check_eq(vecs[k].tag, imm, vecs[k].exp);
        end

        // Register stays cleared across edges while reset is held.
        instruction = 32'hFFF00093;
        imm_sel     = 3'd0;
        @(posedge clk);
        #1 check_eq("q_hold_rst", imm_q, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("q_before_edge", imm_q, 32'h0);
        @(posedge clk);
        #1 check_eq("q_one_edge", imm_q, 32'hFFFFFFFF);

        @(negedge clk);
        instruction = 32'h7FF00093;
        #1 check_eq("q_holds_mid", imm_q, 32'hFFFFFFFF);
        @(posedge clk);
        #1 check_eq("q_follow", imm_q, 32'h000007FF);

        // Mid-cycle reset assertion clears without an edge.
        #2 rst_n = 1'b0;
        #1 check_eq("q_mid_rst", imm_q, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
